// File: rtl/l2_pkg.sv
// Shared definitions for the L2 host tag controller slice.
package l2_pkg;

  localparam int unsigned l2_addr_width_dflt = 64;
  localparam int unsigned l2_nstrms_dflt     = 64;
  localparam int unsigned l2_sid_width_dflt  = $clog2(l2_nstrms_dflt);
  localparam int unsigned l2_ntags_dflt      = 32;
  localparam int unsigned l2_tag_width_dflt  = $clog2(l2_ntags_dflt);

  typedef logic [l2_tag_width_dflt-1:0] tag_t;
  typedef logic [l2_sid_width_dflt-1:0] sid_t;

  // Controller state encoding (INIT seeds the free list, RUN serves traffic)
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/l2_host_tag_ctrl_if.sv
// Request / host command / host response / L2 response handshakes.
interface l2_host_tag_ctrl_if
  import l2_pkg::*;
#(
  parameter int unsigned addr_width   = l2_addr_width_dflt,
  parameter int unsigned nstrms_width = l2_sid_width_dflt,
  parameter int unsigned tag_width    = l2_tag_width_dflt
);
  logic                    i_req_v;
  logic                    i_req_r;
  logic [nstrms_width-1:0] i_req_sid;
  logic [addr_width-1:0]   i_req_ea;
  logic                    o_cmd_v;
  logic                    o_cmd_r;
  logic [addr_width-1:0]   o_cmd_ea;
  logic [tag_width-1:0]    o_cmd_tag;
  logic                    i_hrsp_v;
  logic                    i_hrsp_r;
  logic [tag_width-1:0]    i_hrsp_tag;
  logic                    o_rsp_v;
  logic                    o_rsp_r;
  logic [nstrms_width-1:0] o_rsp_sid;
  logic [tag_width-1:0]    o_rsp_tag;

  // Controller side
  modport slave (
    input  i_req_v, i_req_sid, i_req_ea, o_cmd_r, i_hrsp_v, i_hrsp_tag, o_rsp_r,
    output i_req_r, o_cmd_v, o_cmd_ea, o_cmd_tag, i_hrsp_r, o_rsp_v, o_rsp_sid, o_rsp_tag
  );

  // Environment side (merge, host, response demux)
  modport master (
    output i_req_v, i_req_sid, i_req_ea, o_cmd_r, i_hrsp_v, i_hrsp_tag, o_rsp_r,
    input  i_req_r, o_cmd_v, o_cmd_ea, o_cmd_tag, i_hrsp_r, o_rsp_v, o_rsp_sid, o_rsp_tag
  );
endinterface

// File: rtl/l2_tag_freelist.sv
// FIFO of free host tags; a separate count tells full from empty on wrap.
module l2_tag_freelist
  import l2_pkg::*;
#(
  parameter int unsigned ntags     = l2_ntags_dflt,
  parameter int unsigned tag_width = $clog2(ntags)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [tag_width-1:0] push_tag,
  input  logic                 pop,
  output logic [tag_width-1:0] pop_tag,
  output logic [tag_width:0]   count,
  output logic                 empty,
  output logic                 full
);

  logic [tag_width-1:0] mem [ntags];
  logic [tag_width-1:0] rptr;
  logic [tag_width-1:0] wptr;
  logic                 pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (tag_width+1)'(ntags));
  assign pop_ok  = pop && !empty;
  assign pop_tag = mem[rptr];

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      if (push && !pop_ok) count <= count + 1'b1;
      else if (!push && pop_ok) count <= count - 1'b1;
    end
  end

  // Tag storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_tag;
  end

endmodule

// File: rtl/l2_host_tag_ctrl.sv
// Host tag allocation: free list, tag-to-SID table, command and response stages.
module l2_host_tag_ctrl
  import l2_pkg::*;
#(
  parameter int unsigned addr_width   = l2_addr_width_dflt,
  parameter int unsigned nstrms       = l2_nstrms_dflt,
  parameter int unsigned nstrms_width = $clog2(nstrms),
  parameter int unsigned ntags        = l2_ntags_dflt,
  parameter int unsigned tag_width    = $clog2(ntags)
) (
  input  logic                     clk,
  input  logic                     reset,
  l2_host_tag_ctrl_if.slave        bus,
  output logic [tag_width:0]       o_outstanding,
  output logic                     o_err
);

  logic [0:0]              state;
  logic [tag_width-1:0]    k;
  logic                    run;
  logic [nstrms_width-1:0] tbl [ntags];
  logic [ntags-1:0]        alloc;

  logic                    fl_push;
  logic [tag_width-1:0]    fl_push_tag;
  logic [tag_width-1:0]    fl_pop_tag;
  logic [tag_width:0]      fl_count;
  logic                    fl_empty;
  logic                    fl_full;

  logic                    req_fire;
  logic                    hrsp_fire;
  logic                    hit;
  logic                    free_fire;

  logic                    cmd_v_q;
  logic [addr_width-1:0]   cmd_ea_q;
  logic [tag_width-1:0]    cmd_tag_q;
  logic                    rsp_v_q;
  logic [nstrms_width-1:0] rsp_sid_q;
  logic [tag_width-1:0]    rsp_tag_q;
  logic                    err_q;

  assign run          = (state == ST_RUN);
  assign bus.i_req_r  = run && !fl_empty && (!cmd_v_q || bus.o_cmd_r);
  assign bus.i_hrsp_r = run && (!rsp_v_q || bus.o_rsp_r);
  assign req_fire     = bus.i_req_v && bus.i_req_r;
  assign hrsp_fire    = bus.i_hrsp_v && bus.i_hrsp_r;
  assign hit          = alloc[bus.i_hrsp_tag];
  assign free_fire    = hrsp_fire && hit;

  // INIT seeds tags 0..ntags-1; RUN returns tags from valid responses
  assign fl_push      = !fl_full && (run ? free_fire : 1'b1);
  assign fl_push_tag  = run ? bus.i_hrsp_tag : k;

  assign bus.o_cmd_v   = cmd_v_q;
  assign bus.o_cmd_ea  = cmd_ea_q;
  assign bus.o_cmd_tag = cmd_tag_q;
  assign bus.o_rsp_v   = rsp_v_q;
  assign bus.o_rsp_sid = rsp_sid_q;
  assign bus.o_rsp_tag = rsp_tag_q;
  assign o_err         = err_q;
  assign o_outstanding = run ? ((tag_width+1)'(ntags) - fl_count) : '0;

  l2_tag_freelist #(
    .ntags     (ntags),
    .tag_width (tag_width)
  ) u_freelist (
    .clk      (clk),
    .reset    (reset),
    .push     (fl_push),
    .push_tag (fl_push_tag),
    .pop      (req_fire),
    .pop_tag  (fl_pop_tag),
    .count    (fl_count),
    .empty    (fl_empty),
    .full     (fl_full)
  );

  // INIT counter and state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      k     <= '0;
    end else if (!run) begin
      k <= k + 1'b1;
      if (k == tag_width'(ntags - 1)) state <= ST_RUN;
    end
  end

  // Per-tag allocated bits; a popped tag is never the one being freed
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      alloc <= '0;
    end else begin
      if (free_fire) alloc[bus.i_hrsp_tag] <= 1'b0;
      if (req_fire)  alloc[fl_pop_tag]     <= 1'b1;
    end
  end

  // Tag-to-SID table write on allocation
  always_ff @(posedge clk) begin
    if (req_fire) tbl[fl_pop_tag] <= bus.i_req_sid;
  end

  // Host command stage, held while the host stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_v_q   <= 1'b0;
      cmd_ea_q  <= '0;
      cmd_tag_q <= '0;
    end else if (req_fire) begin
      cmd_v_q   <= 1'b1;
      cmd_ea_q  <= bus.i_req_ea;
      cmd_tag_q <= fl_pop_tag;
    end else if (bus.o_cmd_r) begin
      cmd_v_q   <= 1'b0;
    end
  end

  // L2 response stage and sticky unallocated-tag error
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_v_q   <= 1'b0;
      rsp_sid_q <= '0;
      rsp_tag_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (free_fire) begin
        rsp_v_q   <= 1'b1;
        rsp_sid_q <= tbl[bus.i_hrsp_tag];
        rsp_tag_q <= bus.i_hrsp_tag;
      end else if (bus.o_rsp_r) begin
        rsp_v_q   <= 1'b0;
      end
      if (hrsp_fire && !hit) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_host_tag_ctrl.sv
// Directed and randomized bench for l2_host_tag_ctrl with a queue-based model.
module tb_l2_host_tag_ctrl;

  localparam int unsigned NT = 4;
  localparam int unsigned TW = 2;
  localparam int unsigned SW = 6;
  localparam int unsigned AW = 64;

  logic          clk;
  logic          reset;
  logic [TW:0]   o_outstanding;
  logic          o_err;

  l2_host_tag_ctrl_if #(.addr_width(AW), .nstrms_width(SW), .tag_width(TW)) bus ();

  l2_host_tag_ctrl #(
    .addr_width (AW),
    .nstrms     (64),
    .ntags      (NT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .o_outstanding (o_outstanding),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: free list as a queue, allocation map, tag table
  bit          run;
  int          init_cnt;
  int          fl[$];
  bit          alloc_m[NT];
  int          tbl_m[NT];
  bit          m_cmd_v;
  logic [63:0] m_cmd_ea;
  int          m_cmd_tag;
  bit          m_rsp_v;
  int          m_rsp_sid;
  int          m_rsp_tag;
  bit          m_err;

  int          n_assert;
  int          n_fail;
  bit          dut_rf;
  bit          dut_req_r;
  int          cmd_log[$];
  int          rsp_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: compare against model, log DUT handshakes, advance model
  task automatic step();
    bit er, ehr, rf, hf, v;
    int t;
    #1;
    er  = run && (fl.size() > 0) && (!m_cmd_v || bus.o_cmd_r);
    ehr = run && (!m_rsp_v || bus.o_rsp_r);
    chk("req_r", bus.i_req_r, er);
    chk("hrsp_r", bus.i_hrsp_r, ehr);
    chk("cmd_v", bus.o_cmd_v, m_cmd_v);
    if (m_cmd_v) begin
      chk("cmd_ea", bus.o_cmd_ea, m_cmd_ea);
      chk("cmd_tag", bus.o_cmd_tag, m_cmd_tag);
    end
    chk("rsp_v", bus.o_rsp_v, m_rsp_v);
    if (m_rsp_v) begin
      chk("rsp_sid", bus.o_rsp_sid, m_rsp_sid);
      chk("rsp_tag", bus.o_rsp_tag, m_rsp_tag);
    end
    chk("outstanding", o_outstanding, run ? (NT - fl.size()) : 0);
    chk("err", o_err, m_err);

    dut_req_r = bus.i_req_r;
    dut_rf    = bus.i_req_v && bus.i_req_r;
    if (bus.o_cmd_v && bus.o_cmd_r) cmd_log.push_back(int'(bus.o_cmd_tag));
    if (bus.o_rsp_v && bus.o_rsp_r) rsp_log.push_back(int'(bus.o_rsp_sid));

    rf = bus.i_req_v && er;
    hf = bus.i_hrsp_v && ehr;
    if (reset) begin
      run = 0; init_cnt = 0; fl = {}; m_cmd_v = 0; m_rsp_v = 0; m_err = 0;
      for (int i = 0; i < NT; i++) alloc_m[i] = 0;
    end else if (!run) begin
      init_cnt++;
      if (init_cnt == NT) begin
        run = 1;
        for (int i = 0; i < NT; i++) fl.push_back(i);
      end
    end else begin
      v = hf && alloc_m[bus.i_hrsp_tag];
      if (rf) begin
        t = fl.pop_front();
        alloc_m[t] = 1;
        tbl_m[t]   = int'(bus.i_req_sid);
        m_cmd_v    = 1;
        m_cmd_ea   = bus.i_req_ea;
        m_cmd_tag  = t;
      end else if (bus.o_cmd_r) begin
        m_cmd_v = 0;
      end
      if (v) begin
        t = int'(bus.i_hrsp_tag);
        m_rsp_v   = 1;
        m_rsp_sid = tbl_m[t];
        m_rsp_tag = t;
        alloc_m[t] = 0;
        fl.push_back(t);
      end else begin
        if (hf) m_err = 1;
        if (bus.o_rsp_r) m_rsp_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sids[4];
    int low, idx, n0, cand[$];
    logic [63:0] ea, held_ea;
    sids = '{5, 9, 12, 63};
    n_assert = 0; n_fail = 0;
    run = 0; init_cnt = 0; m_cmd_v = 0; m_rsp_v = 0; m_err = 0;
    m_cmd_ea = '0; m_cmd_tag = 0; m_rsp_sid = 0; m_rsp_tag = 0;
    for (int i = 0; i < NT; i++) begin alloc_m[i] = 0; tbl_m[i] = 0; end

    reset = 1'b1;
    bus.i_req_v = 0; bus.i_req_sid = '0; bus.i_req_ea = '0; bus.o_cmd_r = 0;
    bus.i_hrsp_v = 0; bus.i_hrsp_tag = '0; bus.o_rsp_r = 0;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;

    // requests held valid through INIT; first four tags 0..3
    ea = {$urandom, $urandom};
    bus.i_req_v = 1; bus.i_req_sid = SW'(sids[0]); bus.i_req_ea = ea;
    bus.o_cmd_r = 1; bus.o_rsp_r = 1;
    low = 0; idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      step();
      if (idx == 0 && !dut_req_r) low++;
      if (dut_rf) begin
        idx++;
        if (idx < 4) begin
          ea = {$urandom, $urandom};
          bus.i_req_sid = SW'(sids[idx]); bus.i_req_ea = ea;
        end
      end
    end
    chk("init_ready_low_cycles", low, 4);
    chk("four_requests_done", idx, 4);
    ea = {$urandom, $urandom};
    bus.i_req_sid = SW'(7); bus.i_req_ea = ea;
    step(); step();
    chk("fifth_req_stalled", bus.i_req_r, 0);
    chk("full_outstanding", o_outstanding, 4);
    chk("cmd_log_size", cmd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("first_tags", cmd_log[i], i);

    // return tags 2 then 0; reallocated in that order
    bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(2);
    step();
    bus.i_hrsp_tag = TW'(0);
    step();
    bus.i_hrsp_v = 0;
    step();
    bus.i_req_v = 0;
    step(); step();
    chk("rsp_log_size", rsp_log.size(), 2);
    chk("rsp_sid_first", rsp_log[0], 12);
    chk("rsp_sid_second", rsp_log[1], 5);
    chk("realloc_first", cmd_log[4], 2);
    chk("realloc_second", cmd_log[5], 0);

    // free tags 1 and 3, then stall the host command port
    bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(1);
    step();
    bus.i_hrsp_tag = TW'(3);
    step();
    bus.i_hrsp_v = 0;
    step();
    held_ea = {$urandom, $urandom};
    bus.o_cmd_r = 0; bus.i_req_v = 1; bus.i_req_sid = SW'(20); bus.i_req_ea = held_ea;
    step();
    bus.i_req_ea = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_ea", bus.o_cmd_ea, held_ea);
      chk("stall_tag", bus.o_cmd_tag, 1);
      chk("stall_req_r", bus.i_req_r, 0);
    end
    n0 = cmd_log.size();
    bus.o_cmd_r = 1; bus.i_req_v = 0;
    step(); step(); step();
    chk("release_one_cmd", cmd_log.size(), n0 + 1);
    chk("release_tag", cmd_log[n0], 1);

    // refill, then same-cycle request and response of tag 1 while full
    bus.i_req_v = 1; bus.i_req_sid = SW'(33); bus.i_req_ea = {$urandom, $urandom};
    step();
    bus.i_req_v = 0;
    step();
    chk("full_again", o_outstanding, 4);
    bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(1);
    bus.i_req_v = 1; bus.i_req_sid = SW'(40); bus.i_req_ea = {$urandom, $urandom};
    step();
    bus.i_hrsp_v = 0;
    chk("after_free", o_outstanding, 3);
    step();
    chk("after_realloc", o_outstanding, 4);
    bus.i_req_v = 0;
    step();
    chk("reissued_tag1", cmd_log[cmd_log.size()-1], 1);

    // reset mid-operation, then response for a never-allocated tag
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < NT; c++) step();
    bus.i_hrsp_v = 1; bus.i_hrsp_tag = TW'(3);
    step();
    bus.i_hrsp_v = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("err_sticky", o_err, 1);
      chk("no_rsp_v", bus.o_rsp_v, 0);
      chk("outstanding_zero", o_outstanding, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.i_req_v   = ($urandom % 2) == 0;
      bus.i_req_sid = SW'($urandom % 64);
      bus.i_req_ea  = {$urandom, $urandom};
      bus.o_cmd_r   = ($urandom % 4) != 0;
      bus.o_rsp_r   = ($urandom % 4) != 0;
      cand = {};
      for (int i = 0; i < NT; i++) if (alloc_m[i]) cand.push_back(i);
      if (cand.size() > 0 && ($urandom % 2) == 0) begin
        bus.i_hrsp_v   = 1;
        bus.i_hrsp_tag = TW'(cand[$urandom % cand.size()]);
      end else begin
        bus.i_hrsp_v   = ($urandom % 16) == 0;
        bus.i_hrsp_tag = TW'($urandom % NT);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_host_tag_ctrl.md
Name: l2_host_tag_ctrl

Overview:
- Sits directly downstream of the L2 control top's host request merge and upstream of its host response demux.
- Accepts merged cache-line read requests (EA plus global stream ID) and allocates a host transaction tag from a free list.
- Issues the tagged command to the host interface and records tag-to-SID in a tag table.
- On host response, looks up the SID by tag, presents it to the L2 control response input, then frees the tag.

Parameters:
- addr_width, 64, host address width in bits.
- nstrms, 64, total number of streams.
- nstrms_width, $clog2(nstrms), global stream ID width.
- ntags, 32, number of outstanding host transactions; power of two, at least 2.
- tag_width, $clog2(ntags), host tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- i_req_v  in  1  merged request valid.
- i_req_r  out  1  merged request ready.
- i_req_sid  in  nstrms_width  requesting global stream ID.
- i_req_ea  in  addr_width  cache-line effective address.
- o_cmd_v  out  1  host command valid.
- o_cmd_r  in  1  host command ready.
- o_cmd_ea  out  addr_width  host command address.
- o_cmd_tag  out  tag_width  host command tag.
- i_hrsp_v  in  1  host response valid.
- i_hrsp_r  out  1  host response ready.
- i_hrsp_tag  in  tag_width  tag of completed transaction.
- o_rsp_v  out  1  response to L2 control valid.
- o_rsp_r  in  1  response to L2 control ready.
- o_rsp_sid  out  nstrms_width  stream ID of completed line.
- o_rsp_tag  out  tag_width  tag of completed line, used by the data path for buffer lookup.
- o_outstanding  out  tag_width+1  number of allocated tags.
- o_err  out  1  sticky error: response for an unallocated tag.

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset.
- Reset values: o_cmd_v=0, o_rsp_v=0, o_outstanding=0, o_err=0, i_req_r=0, i_hrsp_r=0. FSM enters INIT.
- FSM INIT:
  - Counter k runs 0..ntags-1 and pushes tag k into the free list, one per cycle.
  - Per-tag allocated bits are cleared.
  - After ntags cycles, transition to RUN.
  - i_req_r=0 and i_hrsp_r=0 throughout INIT.
- FSM RUN:
  - i_req_r = free list non-empty AND (!o_cmd_v OR o_cmd_r).
  - Request handshake:
    - Pop the free-list head as the tag.
    - Write the tag table entry [tag] with sid and set alloc[tag].
    - Register ea/tag into the command stage.
    - o_cmd_v rises the next cycle, giving 1-cycle latency.
  - Command stage holds ea/tag stable while o_cmd_v && !o_cmd_r.
  - i_hrsp_r = !o_rsp_v OR o_rsp_r.
  - Response handshake:
    - Read the tag table; o_rsp_v/o_rsp_sid/o_rsp_tag are registered, 1-cycle latency.
    - Clear alloc[tag] and push the tag to the free list in the same cycle.
- Unallocated tag on response: set o_err, which stays set until reset. No o_rsp_v is generated and the free list is not pushed.
- Simultaneous allocate and free in one cycle:
  - Both occur; o_outstanding is unchanged.
  - A freed tag is not re-allocatable in the same cycle (push visible next cycle).
- Free list empty (ntags outstanding): i_req_r=0; a response the same cycle frees a tag usable the following cycle.
- o_outstanding = ntags - free list count; updates one cycle after the handshake.
- Tag allocation order is FIFO. Tag values are never duplicated among outstanding transactions.
- Reset mid-operation: all in-flight state is discarded, INIT reruns, and outstanding host responses are the environment's responsibility.
- No combinational path from o_cmd_r to i_req_v or from o_rsp_r to i_hrsp_v beyond the ready equations above.

Decomposition:
- Shared package l2_pkg holds:
  - typedef tag_t (logic [tag_width-1:0]);
  - typedef sid_t;
  - localparam for the INIT/RUN state encoding.
- Sub-module l2_tag_freelist: ntags-deep FIFO of tags with push, pop, count, empty and full.
  - Pointers are tag_width wide; a separate count register, tag_width+1 bits wide, distinguishes full from empty on wrap.
- The tag table is a flat ntags x nstrms_width register array inside the top.

Test Plan (ntags=4 unless noted):
- Reset, then requests held valid. Required: i_req_r low for exactly 4 cycles after reset deasserts, then high; first four commands carry tags 0,1,2,3.
- Issue 4 requests sid=5,9,12,63 with no responses. Required: 5th request stalls with i_req_r=0 and o_outstanding=4.
- Return host tags 2 then 0. Required: o_rsp_sid=12 then 5, each 1 cycle after its response handshake; next allocations are tags 2 then 0.
- Hold o_cmd_r=0 for 3 cycles with a request pending. Required: o_cmd_ea/tag stable, i_req_r=0, and exactly one command issued on release.
- Same-cycle request and response of tag 1 while full. Required: o_outstanding stays 4 → 3 → 4 sequence; tag 1 is reissued the cycle after the free.
- Response with tag 3 never allocated (fresh after INIT). Required: o_err=1 sticky, no o_rsp_v, o_outstanding stays 0.
